// File: rtl/writeback_sequencer_pkg.sv
// Shared widths, size codes and types for the writeback sequencer slice.
package writeback_pkg;

  localparam logic [2:0] SIZE_8  = 3'b000;
  localparam logic [2:0] SIZE_8H = 3'b001;
  localparam logic [2:0] SIZE_16 = 3'b010;
  localparam logic [2:0] SIZE_32 = 3'b011;

  localparam logic [2:0] REG_ESP = 3'd4;

  localparam int unsigned REG_W = 32;
  localparam int unsigned SEG_W = 16;
  localparam int unsigned MMX_W = 64;

  typedef enum logic [1:0] {
    SLOT_DST0,
    SLOT_DST1,
    SLOT_ESP,
    SLOT_NONE
  } slot_e;

  // Captured instruction fields; the GPR enables live in the pending mask instead.
  typedef struct packed {
    logic [2:0]       dst0_reg;
    logic [2:0]       dst0_size;
    logic [REG_W-1:0] dst0_data;
    logic [2:0]       dst1_reg;
    logic [2:0]       dst1_size;
    logic [REG_W-1:0] dst1_data;
    logic [REG_W-1:0] esp_data;
    logic             seg_en;
    logic [2:0]       seg_number;
    logic [SEG_W-1:0] seg_data;
    logic             mmx_en;
    logic [2:0]       mmx_number;
    logic [MMX_W-1:0] mmx_data;
  } instr_t;

endpackage

// File: rtl/writeback_sequencer_if.sv
// Execute-to-writeback bundle: completed-instruction inputs and the three writeback buses.
interface writeback_sequencer_if;
  import writeback_pkg::*;

  logic             e_valid;
  logic             e_ready;
  logic             e_dst0_en;
  logic             e_dst1_en;
  logic             e_esp_en;
  logic [2:0]       e_dst0_reg;
  logic [2:0]       e_dst1_reg;
  logic [2:0]       e_dst0_size;
  logic [2:0]       e_dst1_size;
  logic [REG_W-1:0] e_dst0_data;
  logic [REG_W-1:0] e_dst1_data;
  logic [REG_W-1:0] e_esp_data;
  logic             e_seg_en;
  logic [2:0]       e_seg_number;
  logic [SEG_W-1:0] e_seg_data;
  logic             e_mmx_en;
  logic [2:0]       e_mmx_number;
  logic [MMX_W-1:0] e_mmx_data;

  logic [2:0]       wb_reg_number;
  logic             wb_reg_en;
  logic [2:0]       wb_reg_size;
  logic [REG_W-1:0] wb_reg_data;
  logic [2:0]       wb_seg_number;
  logic             wb_seg_en;
  logic [SEG_W-1:0] wb_seg_data;
  logic [2:0]       wb_mmx_number;
  logic             wb_mmx_en;
  logic [MMX_W-1:0] wb_mmx_data;
  logic             wb_retire;

  modport master (
    output e_valid, e_dst0_en, e_dst1_en, e_esp_en,
           e_dst0_reg, e_dst1_reg, e_dst0_size, e_dst1_size,
           e_dst0_data, e_dst1_data, e_esp_data,
           e_seg_en, e_seg_number, e_seg_data,
           e_mmx_en, e_mmx_number, e_mmx_data,
    input  e_ready,
           wb_reg_number, wb_reg_en, wb_reg_size, wb_reg_data,
           wb_seg_number, wb_seg_en, wb_seg_data,
           wb_mmx_number, wb_mmx_en, wb_mmx_data, wb_retire
  );

  modport slave (
    input  e_valid, e_dst0_en, e_dst1_en, e_esp_en,
           e_dst0_reg, e_dst1_reg, e_dst0_size, e_dst1_size,
           e_dst0_data, e_dst1_data, e_esp_data,
           e_seg_en, e_seg_number, e_seg_data,
           e_mmx_en, e_mmx_number, e_mmx_data,
    output e_ready,
           wb_reg_number, wb_reg_en, wb_reg_size, wb_reg_data,
           wb_seg_number, wb_seg_en, wb_seg_data,
           wb_mmx_number, wb_mmx_en, wb_mmx_data, wb_retire
  );

endinterface

// File: rtl/writeback_sequencer_slot_select.sv
// Lowest-set-bit select over the pending GPR write mask {esp, dst1, dst0}.
module wb_slot_select
  import writeback_pkg::*;
(
  input  logic [2:0] pending,
  output slot_e      slot,
  output logic [2:0] next_pending,
  output logic       final_cycle
);

  always_comb begin
    slot         = SLOT_NONE;
    next_pending = pending;
    if (pending[0]) begin
      slot            = SLOT_DST0;
      next_pending[0] = 1'b0;
    end else if (pending[1]) begin
      slot            = SLOT_DST1;
      next_pending[1] = 1'b0;
    end else if (pending[2]) begin
      slot            = SLOT_ESP;
      next_pending[2] = 1'b0;
    end
  end

  // At most one bit left means this issue cycle drains the instruction.
  assign final_cycle = ((pending & (pending - 3'd1)) == '0);

endmodule

// File: rtl/writeback_sequencer.sv
// One-instruction writeback buffer serialising up to three GPR writes onto a single port.
module writeback_sequencer
  import writeback_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  writeback_sequencer_if.slave bus
);

  logic       buf_valid;
  logic [2:0] pending;
  logic       first;
  instr_t     buf_q;

  slot_e      slot;
  logic [2:0] next_pending;
  logic       slot_final;
  logic       final_cycle;
  logic       active;
  logic       accept;

  wb_slot_select u_slot_select (
    .pending      (pending),
    .slot         (slot),
    .next_pending (next_pending),
    .final_cycle  (slot_final)
  );

  // Outputs are gated by reset so nothing leaks while a sequence is being discarded.
  assign active      = buf_valid & ~reset;
  assign final_cycle = buf_valid & slot_final;
  assign bus.e_ready = ~reset & ~flush & (~buf_valid | final_cycle);
  assign accept      = bus.e_valid & bus.e_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
      pending   <= '0;
      first     <= 1'b0;
    end else if (accept) begin
      buf_valid <= 1'b1;
      pending   <= {bus.e_esp_en, bus.e_dst1_en, bus.e_dst0_en};
      first     <= 1'b1;
      buf_q     <= '{
        dst0_reg:   bus.e_dst0_reg,
        dst0_size:  bus.e_dst0_size,
        dst0_data:  bus.e_dst0_data,
        dst1_reg:   bus.e_dst1_reg,
        dst1_size:  bus.e_dst1_size,
        dst1_data:  bus.e_dst1_data,
        esp_data:   bus.e_esp_data,
        seg_en:     bus.e_seg_en,
        seg_number: bus.e_seg_number,
        seg_data:   bus.e_seg_data,
        mmx_en:     bus.e_mmx_en,
        mmx_number: bus.e_mmx_number,
        mmx_data:   bus.e_mmx_data
      };
    end else if (buf_valid) begin
      pending <= next_pending;
      first   <= 1'b0;
      if (final_cycle) buf_valid <= 1'b0;
    end
  end

  always_comb begin
    bus.wb_reg_en     = active & (slot != SLOT_NONE);
    bus.wb_reg_number = buf_q.dst0_reg;
    bus.wb_reg_size   = buf_q.dst0_size;
    bus.wb_reg_data   = buf_q.dst0_data;
    case (slot)
      SLOT_DST1: begin
        bus.wb_reg_number = buf_q.dst1_reg;
        bus.wb_reg_size   = buf_q.dst1_size;
        bus.wb_reg_data   = buf_q.dst1_data;
      end
      SLOT_ESP: begin
        bus.wb_reg_number = REG_ESP;
        bus.wb_reg_size   = SIZE_32;
        bus.wb_reg_data   = buf_q.esp_data;
      end
      default: ;
    endcase
  end

  assign bus.wb_seg_en     = active & first & buf_q.seg_en;
  assign bus.wb_seg_number = buf_q.seg_number;
  assign bus.wb_seg_data   = buf_q.seg_data;
  assign bus.wb_mmx_en     = active & first & buf_q.mmx_en;
  assign bus.wb_mmx_number = buf_q.mmx_number;
  assign bus.wb_mmx_data   = buf_q.mmx_data;
  assign bus.wb_retire     = active & slot_final;

endmodule

// File: tb/tb_writeback_sequencer.sv
// Bench for writeback_sequencer: table vectors, directed corner sequences and a random stream.
module tb_writeback_sequencer;
  import writeback_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  writeback_sequencer_if bus ();

  writeback_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct packed {
    logic        d0_en, d1_en, esp_en;
    logic [2:0]  d0_reg, d1_reg, d0_size, d1_size;
    logic [31:0] d0_data, d1_data, esp_data;
    logic        seg_en;
    logic [2:0]  seg_num;
    logic [15:0] seg_data;
    logic        mmx_en;
    logic [2:0]  mmx_num;
    logic [63:0] mmx_data;
  } ins_t;

  // One expected writeback cycle.
  typedef struct packed {
    logic        reg_en;
    logic [2:0]  num, size;
    logic [31:0] data;
    logic        seg_en;
    logic [2:0]  seg_num;
    logic [15:0] seg_data;
    logic        mmx_en;
    logic [2:0]  mmx_num;
    logic [63:0] mmx_data;
    logic        retire;
  } exp_t;

  typedef struct {
    ins_t             in;
    int               cyc;
    int               nwr;
    logic [2:0][2:0]  num;
    logic [2:0][31:0] data;
    logic             seg0;
  } tv_t;

  exp_t q[$];
  ins_t cur;
  logic cur_valid;
  ins_t idle_ins;
  tv_t  tv[7];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] want);
    nvec++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, want);
    end
  endtask

  // Expand an instruction into its ordered list of writeback cycles.
  task automatic model_push(input ins_t in);
    exp_t w[$];
    exp_t e;
    e = '0;
    if (in.d0_en) begin e.reg_en = 1; e.num = in.d0_reg; e.size = in.d0_size; e.data = in.d0_data; w.push_back(e); end
    if (in.d1_en) begin e.reg_en = 1; e.num = in.d1_reg; e.size = in.d1_size; e.data = in.d1_data; w.push_back(e); end
    if (in.esp_en) begin e.reg_en = 1; e.num = 3'd4; e.size = SIZE_32; e.data = in.esp_data; w.push_back(e); end
    if (w.size() == 0) begin e = '0; w.push_back(e); end
    w[0].seg_en = in.seg_en; w[0].seg_num = in.seg_num; w[0].seg_data = in.seg_data;
    w[0].mmx_en = in.mmx_en; w[0].mmx_num = in.mmx_num; w[0].mmx_data = in.mmx_data;
    w[w.size()-1].retire = 1'b1;
    foreach (w[i]) q.push_back(w[i]);
  endtask

  task automatic drive(input ins_t in, input logic v);
    cur = in;
    cur_valid = v;
    bus.e_valid = v;
    bus.e_dst0_en = in.d0_en;  bus.e_dst1_en = in.d1_en;  bus.e_esp_en = in.esp_en;
    bus.e_dst0_reg = in.d0_reg; bus.e_dst1_reg = in.d1_reg;
    bus.e_dst0_size = in.d0_size; bus.e_dst1_size = in.d1_size;
    bus.e_dst0_data = in.d0_data; bus.e_dst1_data = in.d1_data; bus.e_esp_data = in.esp_data;
    bus.e_seg_en = in.seg_en; bus.e_seg_number = in.seg_num; bus.e_seg_data = in.seg_data;
    bus.e_mmx_en = in.mmx_en; bus.e_mmx_number = in.mmx_num; bus.e_mmx_data = in.mmx_data;
  endtask

  // Compare all outputs against the model at the falling edge, then advance the model.
  task automatic sample();
    exp_t e;
    logic rdy;
    @(negedge clk);
    e = '0;
    if (!reset && q.size() > 0) e = q[0];
    rdy = !reset && !flush && (q.size() <= 1);
    cmp("e_ready", bus.e_ready, rdy);
    cmp("wb_reg_en", bus.wb_reg_en, e.reg_en);
    if (e.reg_en) begin
      cmp("wb_reg_number", bus.wb_reg_number, e.num);
      cmp("wb_reg_size", bus.wb_reg_size, e.size);
      cmp("wb_reg_data", bus.wb_reg_data, e.data);
    end
    cmp("wb_seg_en", bus.wb_seg_en, e.seg_en);
    if (e.seg_en) begin
      cmp("wb_seg_number", bus.wb_seg_number, e.seg_num);
      cmp("wb_seg_data", bus.wb_seg_data, e.seg_data);
    end
    cmp("wb_mmx_en", bus.wb_mmx_en, e.mmx_en);
    if (e.mmx_en) begin
      cmp("wb_mmx_number", bus.wb_mmx_number, e.mmx_num);
      cmp("wb_mmx_data", bus.wb_mmx_data, e.mmx_data);
    end
    cmp("wb_retire", bus.wb_retire, e.retire);
    if (reset) q.delete();
    else begin
      if (q.size() > 0) void'(q.pop_front());
      if (cur_valid && rdy) model_push(cur);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic ins_t mk(input logic d0e, input logic [2:0] d0r, input logic [31:0] d0d,
                              input logic d1e, input logic [2:0] d1r, input logic [31:0] d1d,
                              input logic ee, input logic [31:0] ed);
    ins_t r;
    r = '0;
    r.d0_en = d0e; r.d0_reg = d0r; r.d0_data = d0d; r.d0_size = SIZE_32;
    r.d1_en = d1e; r.d1_reg = d1r; r.d1_data = d1d; r.d1_size = SIZE_32;
    r.esp_en = ee; r.esp_data = ed;
    return r;
  endfunction

  function automatic ins_t rand_ins();
    ins_t r;
    r.d0_en = 1'($urandom); r.d1_en = 1'($urandom); r.esp_en = 1'($urandom);
    r.d0_reg = 3'($urandom); r.d1_reg = 3'($urandom);
    r.d0_size = 3'($urandom_range(0, 3)); r.d1_size = 3'($urandom_range(0, 3));
    r.d0_data = $urandom; r.d1_data = $urandom; r.esp_data = $urandom;
    r.seg_en = 1'($urandom); r.seg_num = 3'($urandom); r.seg_data = 16'($urandom);
    r.mmx_en = 1'($urandom); r.mmx_num = 3'($urandom); r.mmx_data = {$urandom, $urandom};
    return r;
  endfunction

  initial begin
    int cnt_en;
    int cnt_ret;
    ins_t x;
    idle_ins = '0;
    reset = 1'b1;
    flush = 1'b0;
    drive(idle_ins, 1'b0);

    // Table: instruction, cycles, GPR writes, per-cycle reg number/data {c2,c1,c0}, seg in cycle 0.
    tv[0] = '{mk(1, 3'd0, 32'h12345678, 0, 3'd0, 0, 0, 0), 1, 1, {3'd0, 3'd0, 3'd0}, {32'h0, 32'h0, 32'h12345678}, 1'b0};
    tv[1] = '{mk(1, 3'd1, 32'hA, 1, 3'd2, 32'hB, 0, 0), 2, 2, {3'd0, 3'd2, 3'd1}, {32'h0, 32'hB, 32'hA}, 1'b0};
    x = mk(1, 3'd3, 32'hDEADBEEF, 0, 3'd0, 0, 1, 32'h1004);
    x.seg_en = 1; x.seg_num = 3'd3; x.seg_data = 16'h0023;
    tv[2] = '{x, 2, 2, {3'd0, 3'd4, 3'd3}, {32'h0, 32'h1004, 32'hDEADBEEF}, 1'b1};
    x = mk(0, 3'd0, 0, 0, 3'd0, 0, 0, 0);
    x.mmx_en = 1; x.mmx_num = 3'd5; x.mmx_data = 64'h0123_4567_89AB_CDEF;
    tv[3] = '{x, 1, 0, {3'd0, 3'd0, 3'd0}, {32'h0, 32'h0, 32'h0}, 1'b0};
    tv[4] = '{mk(0, 3'd0, 0, 1, 3'd5, 32'h55, 1, 32'hFFC), 2, 2, {3'd0, 3'd4, 3'd5}, {32'h0, 32'hFFC, 32'h55}, 1'b0};
    x = mk(1, 3'd0, 32'h1, 1, 3'd0, 32'h2, 1, 32'h2000);
    x.d1_size = SIZE_16;
    tv[5] = '{x, 3, 3, {3'd4, 3'd0, 3'd0}, {32'h2000, 32'h2, 32'h1}, 1'b0};
    x = mk(0, 3'd0, 0, 0, 3'd0, 0, 0, 0);
    x.seg_en = 1; x.seg_num = 3'd2; x.seg_data = 16'h0010;
    tv[6] = '{x, 1, 0, {3'd0, 3'd0, 3'd0}, {32'h0, 32'h0, 32'h0}, 1'b1};

    #1;
    sample();
    tick();
    reset = 1'b0;

    foreach (tv[i]) begin
      drive(tv[i].in, 1'b1);
      sample();
      tick();
      drive(idle_ins, 1'b0);
      for (int j = 0; j < tv[i].cyc; j++) begin
        sample();
        cmp($sformatf("tv%0d_c%0d_reg_en", i, j), bus.wb_reg_en, (j < tv[i].nwr) ? 1'b1 : 1'b0);
        if (j < tv[i].nwr) begin
          cmp($sformatf("tv%0d_c%0d_num", i, j), bus.wb_reg_number, tv[i].num[j]);
          cmp($sformatf("tv%0d_c%0d_data", i, j), bus.wb_reg_data, tv[i].data[j]);
        end
        cmp($sformatf("tv%0d_c%0d_retire", i, j), bus.wb_retire, (j == tv[i].cyc - 1) ? 1'b1 : 1'b0);
        cmp($sformatf("tv%0d_c%0d_seg_en", i, j), bus.wb_seg_en, (j == 0) ? tv[i].seg0 : 1'b0);
        tick();
      end
    end

    // Five single-write instructions back to back.
    cnt_en = 0;
    cnt_ret = 0;
    for (int c = 0; c < 6; c++) begin
      if (c < 5) drive(mk(1, 3'(c), 32'h100 + 32'(c), 0, 3'd0, 0, 0, 0), 1'b1);
      else drive(idle_ins, 1'b0);
      sample();
      if (c >= 1) begin
        cnt_en += int'(bus.wb_reg_en);
        cnt_ret += int'(bus.wb_retire);
      end
      tick();
    end
    cmp("b2b_reg_en_cycles", 64'(cnt_en), 64'd5);
    cmp("b2b_retires", 64'(cnt_ret), 64'd5);

    // Flush in the second XCHG cycle while the next instruction waits.
    drive(tv[1].in, 1'b1); sample(); tick();
    drive(tv[0].in, 1'b1); sample(); tick();
    flush = 1'b1;
    sample();
    cmp("flush_edx_en", bus.wb_reg_en, 1'b1);
    cmp("flush_edx_num", bus.wb_reg_number, 3'd2);
    cmp("flush_ready", bus.e_ready, 1'b0);
    tick();
    flush = 1'b0;
    sample();
    cmp("flush_ready_after", bus.e_ready, 1'b1);
    tick();
    drive(idle_ins, 1'b0);
    sample();
    cmp("flush_mov_num", bus.wb_reg_number, 3'd0);
    cmp("flush_mov_data", bus.wb_reg_data, 32'h12345678);
    tick();

    // Reset between the two XCHG writes.
    drive(tv[1].in, 1'b1); sample(); tick();
    drive(idle_ins, 1'b0); sample(); tick();
    reset = 1'b1;
    sample();
    cmp("rst_reg_en", bus.wb_reg_en, 1'b0);
    cmp("rst_retire", bus.wb_retire, 1'b0);
    tick();
    reset = 1'b0;
    sample();
    cmp("rst_no_dst1", bus.wb_reg_en, 1'b0);
    cmp("rst_ready_after", bus.e_ready, 1'b1);
    tick();

    // Random stream against the model.
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 6) == 0);
      drive(rand_ins(), ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
      sample();
      tick();
    end
    reset = 1'b0;
    flush = 1'b0;
    drive(idle_ins, 1'b0);
    for (int c = 0; c < 4; c++) begin
      sample();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
